// File: rtl/bp_be_late_wb_arbiter.sv
// -----------------------------------------------------------------------------
// bp_be_late_wb_arbiter
//
// Shares the single late-writeback integer register-file write port, and the
// scoreboard clear port, among num_req_p long-latency producers (divider,
// D$ miss fill, FP-to-int, ...). Each producer hands off {rd, data} through a
// one-entry holding buffer. A round-robin arbiter drains the buffers into the
// port on cycles the early pipeline does not own it. The granted writeback
// drives the scoreboard clear in the same cycle as the register-file write.
//
// Parameters
//   num_req_p          number of late-writeback requesters (2..8)
//   dword_width_gp     integer register width (from processor configuration)
//   reg_addr_width_gp  register address width (from processor configuration)
//
// Ports
//   clk_i              clock
//   reset_i            synchronous active-high reset
//   req_v_i            per-requester writeback valid
//   req_rd_i           per-requester destination register
//   req_data_i         per-requester writeback data
//   req_ready_and_o    per-requester ready; transfer on req_v_i & req_ready_and_o
//   port_busy_i        early pipeline owns the write port; no late grant
//   wb_v_o             late writeback valid (register file + scoreboard clear)
//   wb_rd_o            writeback destination, also the scoreboard clear rd
//   wb_data_o          writeback data
//   wb_grant_o         one-hot id of the requester granted this cycle
//   pending_o          OR of all buffer valids
// -----------------------------------------------------------------------------
module bp_be_late_wb_arbiter #(
    parameter int num_req_p         = 3,
    parameter int dword_width_gp    = 64,
    parameter int reg_addr_width_gp = 5
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,

    input  logic [num_req_p-1:0]                         req_v_i,
    input  logic [num_req_p-1:0][reg_addr_width_gp-1:0]  req_rd_i,
    input  logic [num_req_p-1:0][dword_width_gp-1:0]     req_data_i,
    output logic [num_req_p-1:0]                         req_ready_and_o,

    input  logic                                         port_busy_i,

    output logic                                         wb_v_o,
    output logic [reg_addr_width_gp-1:0]                 wb_rd_o,
    output logic [dword_width_gp-1:0]                    wb_data_o,
    output logic [num_req_p-1:0]                         wb_grant_o,
    output logic                                         pending_o
);

    // Last-grant pointer resets to the top requester so requester 0 is
    // searched first after reset.
    localparam logic [num_req_p-1:0] LP_RR_RESET = {1'b1, {(num_req_p-1){1'b0}}};
    localparam logic [num_req_p-1:0] LP_ONE      = num_req_p'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [num_req_p-1:0]                        r_buf_v;
    logic [num_req_p-1:0][reg_addr_width_gp-1:0] r_buf_rd;
    logic [num_req_p-1:0][dword_width_gp-1:0]    r_buf_data;
    logic [num_req_p-1:0]                        r_rr_last;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [num_req_p-1:0]         w_xfer;
    logic [num_req_p-1:0]         w_cand;
    logic [num_req_p-1:0]         w_above;
    logic [num_req_p-1:0]         w_cand_hi;
    logic [num_req_p-1:0]         w_pick;
    logic [num_req_p-1:0]         w_grant;
    logic                         w_wb_v;
    logic [reg_addr_width_gp-1:0] w_wb_rd;
    logic [dword_width_gp-1:0]    w_wb_data;
    logic                         w_dup_rd;

    // Ready depends only on the registered buffer state, so producers see no
    // combinational path from their own valid or from port_busy_i. It stays
    // low during the drain cycle, capping each producer at one entry per two
    // cycles and making a same-cycle grant and refill impossible.
    assign w_xfer = req_v_i & ~r_buf_v;

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    // Circular search starting one past the last grant, done without any
    // variable indexing: first look for the lowest candidate strictly above
    // the last grant; if there is none, wrap around to the lowest candidate.
    // For a one-hot r_rr_last, (r_rr_last - 1) sets every bit below it, so
    // the complement of (last | last-1) is the "strictly above" mask.
    assign w_cand    = r_buf_v & {num_req_p{~port_busy_i}};
    assign w_above   = ~(r_rr_last | (r_rr_last - LP_ONE));
    assign w_cand_hi = w_cand & w_above;
    assign w_pick    = (|w_cand_hi) ? w_cand_hi : w_cand;
    // x & -x isolates the lowest set bit.
    assign w_grant   = w_pick & (~w_pick + LP_ONE);
    assign w_wb_v    = |w_cand;

    // One-hot AND-OR mux; an all-zero grant yields zero rd and data, so the
    // outputs hold 0 whenever there is no writeback.
    always_comb begin
        // NOTE: every signal written here gets a default before any
        // conditional logic, so no path leaves it unassigned and no latch
        // is inferred.
        w_wb_rd   = '0;
        w_wb_data = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_wb_rd   = w_wb_rd   | ({reg_addr_width_gp{w_grant[i]}} & r_buf_rd[i]);
            w_wb_data = w_wb_data | ({dword_width_gp{w_grant[i]}}    & r_buf_data[i]);
        end
    end

    // -------------------------------------------------------------------------
    // Control state: buffer valids and last-grant pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset_i) begin
            r_buf_v   <= '0;
            r_rr_last <= LP_RR_RESET;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (w_xfer[i]) begin
                    r_buf_v[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_buf_v[i] <= 1'b0;
                end
            end
            if (w_wb_v) begin
                r_rr_last <= w_grant;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Buffer payload
    // -------------------------------------------------------------------------
    // NOTE: the rd/data payload is deliberately left out of reset; it is only
    // observed when the matching valid bit is set, and the valid bits reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_req_p; i++) begin
            if (w_xfer[i]) begin
                r_buf_rd[i]   <= req_rd_i[i];
                r_buf_data[i] <= req_data_i[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready_and_o = ~r_buf_v;
    assign wb_v_o          = w_wb_v;
    assign wb_rd_o         = w_wb_rd;
    assign wb_data_o       = w_wb_data;
    assign wb_grant_o      = w_grant;
    assign pending_o       = |r_buf_v;

    // -------------------------------------------------------------------------
    // Simulation check: the scoreboard forbids two outstanding writers to one
    // rd, so two valid buffers must never carry the same destination.
    // -------------------------------------------------------------------------
    always_comb begin
        w_dup_rd = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            for (int j = i + 1; j < num_req_p; j++) begin
                if (r_buf_v[i] && r_buf_v[j] && (r_buf_rd[i] == r_buf_rd[j])) begin
                    w_dup_rd = 1'b1;
                end
            end
        end
    end

    a_unique_rd: assert property (@(posedge clk_i) disable iff (reset_i) !w_dup_rd);

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_be_late_wb_arbiter
//
// Directed bench for bp_be_late_wb_arbiter with three requesters. Inputs are
// driven shortly after each rising edge; outputs are sampled 1 time unit after
// the inputs settle, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_bp_be_late_wb_arbiter;

    localparam int N  = 3;
    localparam int RW = 5;
    localparam int DW = 64;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic [N-1:0]          req_v_i;
    logic [N-1:0][RW-1:0]  req_rd_i;
    logic [N-1:0][DW-1:0]  req_data_i;
    logic [N-1:0]          req_ready_and_o;
    logic                  port_busy_i;
    logic                  wb_v_o;
    logic [RW-1:0]         wb_rd_o;
    logic [DW-1:0]         wb_data_o;
    logic [N-1:0]          wb_grant_o;
    logic                  pending_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    bp_be_late_wb_arbiter #(
        .num_req_p         (N),
        .dword_width_gp    (DW),
        .reg_addr_width_gp (RW)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .req_v_i         (req_v_i),
        .req_rd_i        (req_rd_i),
        .req_data_i      (req_data_i),
        .req_ready_and_o (req_ready_and_o),
        .port_busy_i     (port_busy_i),
        .wb_v_o          (wb_v_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .wb_grant_o      (wb_grant_o),
        .pending_o       (pending_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        req_v_i     = '0;
        port_busy_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    int xfers;
    int exp_next;

    initial begin
        reset_i     = 1'b1;
        req_v_i     = '0;
        req_rd_i    = '0;
        req_data_i  = '0;
        port_busy_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        #1;

        // ---------------- reset state ----------------
        check("rst_wb_v",    64'(wb_v_o),          64'd0);
        check("rst_grant",   64'(wb_grant_o),      64'd0);
        check("rst_pending", 64'(pending_o),       64'd0);
        check("rst_ready",   64'(req_ready_and_o), 64'h7);
        check("rst_rd",      64'(wb_rd_o),         64'd0);
        check("rst_data",    wb_data_o,            64'd0);

        // ---------------- single request ----------------
        req_v_i       = 3'b010;
        req_rd_i[1]   = 5'd5;
        req_data_i[1] = 64'hDEAD_BEEF;
        tick();                         // edge 0 -> cycle 1
        req_v_i = '0;
        #1;
        check("single_wb_v",    64'(wb_v_o),          64'd1);
        check("single_rd",      64'(wb_rd_o),         64'd5);
        check("single_data",    wb_data_o,            64'hDEAD_BEEF);
        check("single_grant",   64'(wb_grant_o),      64'b010);
        check("single_ready_c1",64'(req_ready_and_o), 64'b101);
        check("single_pending", 64'(pending_o),       64'd1);
        tick();                         // cycle 2
        check("single_ready_c2",64'(req_ready_and_o), 64'b111);
        check("single_idle_v",  64'(wb_v_o),          64'd0);
        check("single_idle_rd", 64'(wb_rd_o),         64'd0);
        check("single_pend_c2", 64'(pending_o),       64'd0);

        // ---------------- round robin ----------------
        do_reset();
        req_v_i       = 3'b111;
        req_rd_i[0]   = 5'd1;  req_data_i[0] = 64'h100;
        req_rd_i[1]   = 5'd2;  req_data_i[1] = 64'h200;
        req_rd_i[2]   = 5'd3;  req_data_i[2] = 64'h300;
        tick();                         // cycle 1
        req_v_i = '0;
        #1;
        check("rr_c1_grant", 64'(wb_grant_o), 64'b001);
        check("rr_c1_rd",    64'(wb_rd_o),    64'd1);
        check("rr_c1_data",  wb_data_o,       64'h100);
        tick();                         // cycle 2
        check("rr_c2_grant", 64'(wb_grant_o),      64'b010);
        check("rr_c2_rd",    64'(wb_rd_o),         64'd2);
        check("rr_c2_ready", 64'(req_ready_and_o), 64'b001);
        // refill requester 0 while requester 2 is still waiting
        req_v_i       = 3'b001;
        req_rd_i[0]   = 5'd4;
        req_data_i[0] = 64'h400;
        tick();                         // cycle 3: candidates {0,2}, last = 1
        req_v_i = '0;
        #1;
        check("rr_c3_grant", 64'(wb_grant_o), 64'b100);
        check("rr_c3_rd",    64'(wb_rd_o),    64'd3);
        tick();                         // cycle 4
        check("rr_c4_grant", 64'(wb_grant_o), 64'b001);
        check("rr_c4_data",  wb_data_o,       64'h400);
        tick();                         // cycle 5: drained
        check("rr_c5_wb_v",  64'(wb_v_o),     64'd0);

        // grant requester 1, then load 0 and 2 together: 2 must win
        req_v_i       = 3'b010;
        req_rd_i[1]   = 5'd9;
        req_data_i[1] = 64'h900;
        tick();
        req_v_i = '0;
        #1;
        check("rr_g1_grant", 64'(wb_grant_o), 64'b010);
        check("rr_g1_rd",    64'(wb_rd_o),    64'd9);
        tick();
        req_v_i       = 3'b101;
        req_rd_i[0]   = 5'd10; req_data_i[0] = 64'hA00;
        req_rd_i[2]   = 5'd11; req_data_i[2] = 64'hB00;
        tick();
        req_v_i = '0;
        #1;
        check("rr_02_first",  64'(wb_grant_o), 64'b100);
        check("rr_02_rd1",    64'(wb_rd_o),    64'd11);
        tick();
        check("rr_02_second", 64'(wb_grant_o), 64'b001);
        check("rr_02_rd2",    64'(wb_rd_o),    64'd10);
        tick();

        // ---------------- busy blocking ----------------
        req_v_i       = 3'b100;
        req_rd_i[2]   = 5'd7;
        req_data_i[2] = 64'h77;
        tick();                         // cycle 1
        req_v_i     = '0;
        port_busy_i = 1'b1;
        #1;
        for (int c = 1; c <= 4; c++) begin
            check("busy_wb_v",    64'(wb_v_o),     64'd0);
            check("busy_pending", 64'(pending_o),  64'd1);
            check("busy_grant",   64'(wb_grant_o), 64'd0);
            tick();
        end
        port_busy_i = 1'b0;             // cycle 5
        #1;
        check("busy_rel_v",     64'(wb_v_o),     64'd1);
        check("busy_rel_rd",    64'(wb_rd_o),    64'd7);
        check("busy_rel_grant", 64'(wb_grant_o), 64'b100);
        tick();
        check("busy_after_pend", 64'(pending_o), 64'd0);

        // ---------------- back-to-back from one producer ----------------
        do_reset();
        xfers       = 0;
        req_rd_i[0] = 5'd6;
        for (int c = 0; c <= 6; c++) begin
            req_v_i       = (c < 6) ? 3'b001 : 3'b000;
            req_data_i[0] = 64'(c);
            #1;
            check("b2b_wb_v", 64'(wb_v_o), 64'((c % 2) == 1));
            if ((c % 2) == 1) begin
                check("b2b_data", wb_data_o, 64'(c - 1));
            end
            if (req_v_i[0] && req_ready_and_o[0]) begin
                xfers++;
            end
            tick();
        end
        req_v_i = '0;
        check("b2b_xfers", 64'(xfers), 64'd3);

        // ---------------- reset mid-operation ----------------
        // last grant went to requester 0, so without a reset requester 1
        // would be searched first.
        port_busy_i   = 1'b1;
        req_v_i       = 3'b110;
        req_rd_i[1]   = 5'd12;
        req_rd_i[2]   = 5'd13;
        tick();
        req_v_i = '0;
        #1;
        check("mid_pend_before", 64'(pending_o), 64'd1);
        check("mid_wb_v_before", 64'(wb_v_o),    64'd0);
        reset_i = 1'b1;
        tick();
        reset_i     = 1'b0;
        port_busy_i = 1'b0;
        #1;
        check("mid_wb_v",    64'(wb_v_o),          64'd0);
        check("mid_pending", 64'(pending_o),       64'd0);
        check("mid_ready",   64'(req_ready_and_o), 64'b111);
        req_v_i       = 3'b011;
        req_rd_i[0]   = 5'd14; req_data_i[0] = 64'hE0;
        req_rd_i[1]   = 5'd15; req_data_i[1] = 64'hF0;
        tick();
        req_v_i = '0;
        #1;
        check("mid_next_grant", 64'(wb_grant_o), 64'b001);
        check("mid_next_rd",    64'(wb_rd_o),    64'd14);
        tick();
        check("mid_second",     64'(wb_grant_o), 64'b010);
        tick();

        // ---------------- starvation bound ----------------
        // With requesters 0 and 1 always requesting, grants alternate 0,1,0,1
        // across the non-busy cycles regardless of busy gaps.
        do_reset();
        req_rd_i[0]   = 5'd1; req_data_i[0] = 64'hA0;
        req_rd_i[1]   = 5'd2; req_data_i[1] = 64'hB1;
        req_v_i       = 3'b011;
        exp_next      = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            port_busy_i = 1'($urandom_range(0, 1));
            #1;
            check("starve_wb_v", 64'(wb_v_o), 64'(!port_busy_i));
            if (!port_busy_i) begin
                check("starve_grant", 64'(wb_grant_o), (exp_next == 0) ? 64'b001 : 64'b010);
                check("starve_rd",    64'(wb_rd_o),    (exp_next == 0) ? 64'd1   : 64'd2);
                check("starve_data",  wb_data_o,       (exp_next == 0) ? 64'hA0  : 64'hB1);
                exp_next = 1 - exp_next;
            end
        end
        req_v_i     = '0;
        port_busy_i = 1'b0;
        tick();
        tick();
        tick();
        check("starve_drain", 64'(pending_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
